// File: rtl/cim_add_column.sv
// Array-side responder for the bit-serial add sequencer: operand/result rows,
// per-column carry latches, protocol checker and DONE-triggered result capture.

// One adder column: v1/v2 operand rows, result row p, carry latch, captured sum.
module cim_add_lane #(
  parameter int BITS = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ld,
  input  logic [BITS-1:0] ld_a,
  input  logic [BITS-1:0] ld_b,
  input  logic [BITS-1:0] rwl,
  input  logic [BITS-1:0] wwl,   // already gated to a legal one-hot or zero
  input  logic            c_en,
  input  logic            clr,
  input  logic            cap,
  output logic [BITS:0]   res
);
  logic [BITS-1:0] v1, v2, p;
  logic            carry;
  logic            a, b, s, maj;

  // Bitline read: the selected cell drives the line, no selection reads 0.
  assign a   = |(v1 & rwl);
  assign b   = |(v2 & rwl);
  assign s   = a ^ b ^ carry;
  assign maj = (a & b) | (a & carry) | (b & carry);

  // Operand load, result write, carry update and sum capture; CLR wins over writes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1    <= '0;
      v2    <= '0;
      p     <= '0;
      carry <= 1'b0;
      res   <= '0;
    end else begin
      if (ld) begin
        v1 <= ld_a;
        v2 <= ld_b;
      end
      if (clr) begin
        carry <= 1'b0;
        p     <= '0;
        res   <= '0;
      end else begin
        if (c_en) carry <= maj;
        p <= (p & ~wwl) | ({BITS{s}} & wwl);
        if (cap) res <= {carry, p};
      end
    end
  end
endmodule

module cim_add_column #(
  parameter int BITS = 8,
  parameter int COLS = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   ld_en,
  input  logic [COLS*BITS-1:0]   ld_a,
  input  logic [COLS*BITS-1:0]   ld_b,
  input  logic [BITS-1:0]        RWLv1,
  input  logic [BITS-1:0]        RWLv2,
  input  logic [BITS-1:0]        WWLp,
  input  logic                   C_EN,
  input  logic                   CLR,
  input  logic                   DONE,
  output logic [COLS*(BITS+1)-1:0] sum,
  output logic                   sum_valid,
  output logic                   proto_err
);
  logic                       idle, ld_ok, wr_ok, done_q, done_rise, viol;
  logic [BITS-1:0]            wwl_g;
  logic [COLS-1:0][BITS:0]    res;

  assign idle      = (RWLv1 == '0) && (RWLv2 == '0) && (WWLp == '0);
  assign ld_ok     = ld_en && idle;
  // A multi-hot write wordline performs no write at all.
  assign wr_ok     = $onehot(WWLp);
  assign wwl_g     = wr_ok ? WWLp : '0;
  assign done_rise = DONE && !done_q;

  assign viol = (RWLv1 != RWLv2)
             || ((RWLv1 != '0) && !$onehot(RWLv1))
             || ((WWLp  != '0) && !wr_ok)
             || ((WWLp  != '0) && (WWLp != RWLv1))
             || (C_EN && (RWLv1 == '0))
             || (ld_en && !idle);

  genvar c;
  generate
    for (c = 0; c < COLS; c++) begin : g_col
      cim_add_lane #(.BITS(BITS)) u_lane (
        .clk   (clk),
        .rst_n (rst_n),
        .ld    (ld_ok),
        .ld_a  (ld_a[c*BITS +: BITS]),
        .ld_b  (ld_b[c*BITS +: BITS]),
        .rwl   (RWLv1),
        .wwl   (wwl_g),
        .c_en  (C_EN),
        .clr   (CLR),
        .cap   (done_rise),
        .res   (res[c])
      );
      assign sum[c*(BITS+1) +: BITS+1] = res[c];
    end
  endgenerate

  // DONE edge detect, result-valid flag and sticky protocol flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_q    <= 1'b0;
      sum_valid <= 1'b0;
      proto_err <= 1'b0;
    end else begin
      done_q <= DONE;
      if (CLR)            sum_valid <= 1'b0;
      else if (done_rise) sum_valid <= 1'b1;
      if (viol)           proto_err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_cim_add_column.sv
// Self-checking bench: drives the sequencer strobes and compares against a + b.
module tb_cim_add_column;
  localparam int BITS = 8;
  localparam int COLS = 4;
  localparam int SW   = COLS*(BITS+1);

  logic                 clk = 0, rst_n = 0;
  logic                 ld_en = 0, C_EN = 0, CLR = 0, DONE = 0;
  logic [COLS*BITS-1:0] ld_a = '0, ld_b = '0;
  logic [BITS-1:0]      RWLv1 = '0, RWLv2 = '0, WWLp = '0;
  logic [SW-1:0]        sum;
  logic                 sum_valid, proto_err;

  int total = 0, bad = 0;

  cim_add_column #(.BITS(BITS), .COLS(COLS)) dut (
    .clk(clk), .rst_n(rst_n), .ld_en(ld_en), .ld_a(ld_a), .ld_b(ld_b),
    .RWLv1(RWLv1), .RWLv2(RWLv2), .WWLp(WWLp), .C_EN(C_EN), .CLR(CLR),
    .DONE(DONE), .sum(sum), .sum_valid(sum_valid), .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic cyc();
    @(posedge clk); #1;
  endtask

  // Reference: each column's result is the plain 9-bit sum of its operands.
  function automatic logic [SW-1:0] model(input logic [COLS*BITS-1:0] a,
                                          input logic [COLS*BITS-1:0] b);
    logic [SW-1:0] r;
    r = '0;
    for (int c = 0; c < COLS; c++)
      r[c*(BITS+1) +: BITS+1] = (BITS+1)'(a[c*BITS +: BITS]) + (BITS+1)'(b[c*BITS +: BITS]);
    return r;
  endfunction

  task automatic do_reset();
    rst_n = 0; ld_en = 0; C_EN = 0; CLR = 0; DONE = 0;
    RWLv1 = '0; RWLv2 = '0; WWLp = '0;
    cyc(); rst_n = 1; cyc();
  endtask

  task automatic load(input logic [COLS*BITS-1:0] a, input logic [COLS*BITS-1:0] b);
    ld_a = a; ld_b = b; ld_en = 1; cyc(); ld_en = 0;
  endtask

  task automatic clear();
    CLR = 1; cyc(); CLR = 0;
  endtask

  // ADD / STORE / CHECK for bits lo..hi.
  task automatic run_bits(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      RWLv1 = BITS'(1) << i; RWLv2 = RWLv1;
      cyc();
      WWLp = RWLv1; cyc(); WWLp = '0;
      C_EN = 1; cyc(); C_EN = 0;
    end
    RWLv1 = '0; RWLv2 = '0;
  endtask

  task automatic finish_done();
    DONE = 1; cyc(); DONE = 0; cyc();
  endtask

  task automatic add_check(input string name, input logic [COLS*BITS-1:0] a,
                           input logic [COLS*BITS-1:0] b);
    logic [SW-1:0] exp;
    exp = model(a, b);
    clear(); load(a, b); run_bits(0, BITS-1); finish_done();
    total++;
    if (sum !== exp || sum_valid !== 1'b1 || proto_err !== 1'b0) begin
      bad++;
      $display("FAIL %s: sum=%h valid=%b err=%b, want sum=%h valid=1 err=0",
               name, sum, sum_valid, proto_err, exp);
    end
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if (sum !== '0 || sum_valid !== 1'b0 || proto_err !== 1'b0) begin
      bad++;
      $display("FAIL reset: sum=%h valid=%b err=%b, want 0/0/0", sum, sum_valid, proto_err);
    end
  endtask

  task automatic test_directed();
    do_reset();
    add_check("add_5a_3c", {COLS{8'h5A}}, {COLS{8'h3C}});
    add_check("ovf_ff_01", {COLS{8'hFF}}, {COLS{8'h01}});
    add_check("ovf_ff_ff", {COLS{8'hFF}}, {COLS{8'hFF}});
    add_check("columns",   {8'h01, 8'h80, 8'hAA, 8'h00}, {8'hFF, 8'h80, 8'h55, 8'h00});
    total++;
    if (sum !== {9'h100, 9'h100, 9'h0FF, 9'h000}) begin
      bad++;
      $display("FAIL columns_const: sum=%h want %h", sum, {9'h100, 9'h100, 9'h0FF, 9'h000});
    end
  endtask

  task automatic test_random();
    logic [COLS*BITS-1:0] a, b;
    do_reset();
    for (int k = 0; k < 8; k++) begin
      for (int c = 0; c < COLS; c++) begin
        a[c*BITS +: BITS] = BITS'($urandom);
        b[c*BITS +: BITS] = BITS'($urandom);
      end
      add_check("random", a, b);
    end
  endtask

  task automatic test_proto();
    do_reset();
    RWLv1 = 8'h02; RWLv2 = 8'h04; cyc(); RWLv1 = '0; RWLv2 = '0;
    total++;
    if (proto_err !== 1'b1) begin bad++; $display("FAIL rwl_mismatch: err=%b want 1", proto_err); end
    clear(); cyc();
    total++;
    if (proto_err !== 1'b1) begin bad++; $display("FAIL err_sticky: err=%b want 1", proto_err); end
    // Multi-hot write wordline: s=1 on bit 0, yet p must stay empty.
    do_reset();
    load({COLS{8'hFF}}, {COLS{8'h00}});
    RWLv1 = 8'h01; RWLv2 = 8'h01; WWLp = 8'h03; cyc();
    WWLp = '0; RWLv1 = '0; RWLv2 = '0;
    total++;
    if (proto_err !== 1'b1) begin bad++; $display("FAIL wwl_multihot_err: err=%b want 1", proto_err); end
    finish_done();
    total++;
    if (sum !== '0 || sum_valid !== 1'b1) begin
      bad++; $display("FAIL wwl_multihot_p: sum=%h valid=%b want 0/1", sum, sum_valid);
    end
    // C_EN without a read wordline is flagged.
    do_reset();
    C_EN = 1; cyc(); C_EN = 0;
    total++;
    if (proto_err !== 1'b1) begin bad++; $display("FAIL cen_norwl: err=%b want 1", proto_err); end
  endtask

  task automatic test_clr_priority();
    do_reset();
    load({COLS{8'hFF}}, {COLS{8'h01}});
    run_bits(0, 0);                      // carry is now 1 in every column
    RWLv1 = 8'h02; RWLv2 = 8'h02;        // a=1,b=0,carry=1 would keep carry=1
    C_EN = 1; CLR = 1; cyc(); C_EN = 0; CLR = 0;
    RWLv1 = '0; RWLv2 = '0;
    finish_done();
    total++;
    if (sum !== '0) begin bad++; $display("FAIL clr_vs_cen: sum=%h want 0", sum); end
  endtask

  task automatic test_done_level();
    do_reset();
    load({COLS{8'h12}}, {COLS{8'h34}});
    run_bits(0, BITS-1);
    DONE = 1; cyc();
    total++;
    if (sum !== model({COLS{8'h12}}, {COLS{8'h34}}) || sum_valid !== 1'b1) begin
      bad++; $display("FAIL done_first: sum=%h valid=%b", sum, sum_valid);
    end
    clear();                             // DONE still high
    for (int i = 0; i < 4; i++) cyc();
    DONE = 0;
    total++;
    if (sum_valid !== 1'b0) begin bad++; $display("FAIL done_held: valid=%b want 0", sum_valid); end
    cyc();
  endtask

  task automatic test_ld_busy();
    logic [COLS*BITS-1:0] a, b;
    a = {8'h11, 8'h22, 8'h33, 8'h44}; b = {8'h05, 8'h06, 8'h07, 8'h08};
    do_reset();
    load(a, b);
    RWLv1 = 8'h01; RWLv2 = 8'h01; cyc();
    WWLp = 8'h01; ld_a = '1; ld_b = '1; ld_en = 1; cyc(); ld_en = 0; WWLp = '0;
    C_EN = 1; cyc(); C_EN = 0;
    run_bits(1, BITS-1);
    finish_done();
    total++;
    if (sum !== model(a, b) || proto_err !== 1'b1) begin
      bad++; $display("FAIL ld_busy: sum=%h err=%b want sum=%h err=1", sum, proto_err, model(a, b));
    end
  endtask

  task automatic test_reset_mid();
    logic [COLS*BITS-1:0] a, b;
    a = {8'h9C, 8'h01, 8'h7F, 8'hE3}; b = {8'h27, 8'hFE, 8'h80, 8'h1D};
    do_reset();
    add_check("pre_reset", {COLS{8'h5A}}, {COLS{8'h3C}});
    load(a, b);
    run_bits(0, 3);
    RWLv1 = 8'h10; RWLv2 = 8'h10;
    #3 rst_n = 0; #1;
    total++;
    if (sum !== '0 || sum_valid !== 1'b0) begin
      bad++; $display("FAIL async_reset: sum=%h valid=%b want 0/0", sum, sum_valid);
    end
    RWLv1 = '0; RWLv2 = '0;
    cyc(); rst_n = 1; cyc();
    add_check("after_reset", a, b);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_proto();
    test_clr_priority();
    test_done_level();
    test_ld_busy();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/cim_add_column.md
Name: cim_add_column

Overview:
- Array-side responder to the bit-serial add sequencer in the compute-in-memory engine.
- Holds the operand rows v1 and v2 and the result row p for COLS parallel columns, plus a per-column carry latch.
- Reacts to the sequencer's read-wordline, write-wordline, carry-enable, clear and done strobes, and produces the sum and carry-out.
- Used as the synthesizable array model in integration and as the digital stand-in for the macro's peripheral logic.

Parameters:
- BITS, 8, operand width in bits; equals the width of the wordline buses.
- COLS, 4, number of independent adder columns operating in lockstep.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- ld_en  in  1  operand load strobe; accepted only when the block is idle (all wordlines zero).
- ld_a  in  COLS*BITS  v1 operand row; column c occupies bits [c*BITS +: BITS].
- ld_b  in  COLS*BITS  v2 operand row; same packing as ld_a.
- RWLv1  in  BITS  one-hot read wordline for v1; bit i selects operand bit i.
- RWLv2  in  BITS  one-hot read wordline for v2.
- WWLp  in  BITS  one-hot write wordline for the result row p.
- C_EN  in  1  carry latch enable.
- CLR  in  1  clear strobe from the sequencer.
- DONE  in  1  sequence-complete level from the sequencer.
- sum  out  COLS*(BITS+1)  per-column result: carry-out in the MSB, p[BITS-1:0] below it.
- sum_valid  out  1  result is valid.
- proto_err  out  1  sticky protocol violation flag.

Behaviour:
- Reset (async, rst_n=0): v1, v2, p and carry all zero; sum=0, sum_valid=0, proto_err=0.
- Load: when ld_en=1 and RWLv1, RWLv2 and WWLp are all zero, v1<=ld_a and v2<=ld_b on the next edge.
  - ld_en while any wordline is nonzero: operands unchanged, proto_err<=1.
- Read path (combinational): for column c, idx is the set bit of RWLv1.
  - a=v1[c][idx], b=v2[c][idx], s=a^b^carry[c].
  - When RWLv1=0, a=b=0.
- Write: when WWLp is one-hot at bit j, p[c][j]<=s on the edge, using the carry value from before that edge.
- Carry: when C_EN=1, carry[c]<=maj(a,b,carry[c]).
  - If WWLp and C_EN are high in the same cycle, p takes s computed with the old carry and carry updates; there is no hazard.
- Expected per-bit sequence: 3 cycles.
  - ADD: RWL only.
  - STORE: RWL+WWLp.
  - CHECK: RWL+C_EN.
  - Repeats for bits 0..BITS-1, LSB first, then DONE.
- CLR=1 on an edge: carry<=0, p<=0, sum_valid<=0. Operands are kept.
  - CLR has priority over a write or C_EN in the same cycle.
- DONE rising edge (DONE=1 now, 0 on the previous cycle): sum[c]<={carry[c], p[c]} and sum_valid<=1.
  - Both hold until CLR, reset, or the next DONE rising edge.
  - A DONE level held high does not re-capture.
- proto_err is sticky and cleared only by rst_n. It sets on any of:
  - RWLv1 != RWLv2;
  - RWLv1 or WWLp nonzero and not one-hot;
  - WWLp nonzero with WWLp != RWLv1;
  - C_EN=1 with RWLv1=0;
  - ld_en during activity (see Load).
- Violating writes and carry updates are still performed exactly as the rules above define (for a non-one-hot WWLp, no write occurs). The flag is diagnostic only.
- Reset mid-sequence: all state clears immediately. Later strobes operate on zero operands.
- Latency: p bit j is visible 1 cycle after the STORE edge; sum is visible 1 cycle after the DONE rise.

Test Plan:
- Load a=8'h5A, b=8'h3C (all columns), run the full 24-cycle strobe sequence then DONE -> sum=9'h096, sum_valid=1, proto_err=0.
- Overflow: a=8'hFF, b=8'h01 -> sum=9'h100. Then a=8'hFF, b=8'hFF after CLR+reload -> sum=9'h1FE.
- Per-column independence with COLS=4: a={8'h01,8'h80,8'hAA,8'h00}, b={8'hFF,8'h80,8'h55,8'h00} -> sums {9'h100,9'h100,9'h0FF,9'h000}.
- Protocol errors: RWLv1=8'h02 with RWLv2=8'h04 -> proto_err=1 and stays 1 through CLR. WWLp=8'h03 -> proto_err=1 and p unchanged.
- CLR with C_EN in the same cycle -> carry=0. DONE held high for 5 cycles -> single capture. ld_en during STORE -> operands unchanged, proto_err=1.
- rst_n pulsed low at bit 4 of an add -> sum=0, sum_valid=0, carry=0 asynchronously. Reload and rerun gives the correct sum.
